// File: rtl/hazard_ctrl_sb_if.sv
// hazard_ctrl_sb_if: datapath-side hazard signals between the pipeline and the hazard unit
interface hazard_ctrl_sb_if #(parameter int REG_AW = 5, parameter int CNT_W = 16);
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic branchD, mdstartE, memaccessM, dmem_ready;
  logic [1:0] forwardAE, forwardBE;
  logic forwardAD, forwardBD;
  logic stallF, stallD, stallE, stallM, flushE, flushM, flushW;
  logic md_busy, md_done;
  logic [REG_AW-1:0] md_wreg;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, mdstartE, memaccessM, dmem_ready,
    input  forwardAE, forwardBE, forwardAD, forwardBD,
           stallF, stallD, stallE, stallM, flushE, flushM, flushW,
           md_busy, md_done, md_wreg, stall_cycles
  );
  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, mdstartE, memaccessM, dmem_ready,
    output forwardAE, forwardBE, forwardAD, forwardBD,
           stallF, stallD, stallE, stallM, flushE, flushM, flushW,
           md_busy, md_done, md_wreg, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_sb.sv
// hazard_ctrl_sb: forwarding, stall/flush control and mul/div scoreboard for a 5-stage pipeline
module hazard_ctrl_sb #(
  parameter int REG_AW = 5,
  parameter int NREG   = 32,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_ctrl_sb_if.slave h
);
  localparam int CW = $clog2(MD_LAT);
  typedef enum logic {IDLE, BUSY} st_t;
  st_t st;
  logic [CW-1:0] cnt;
  logic [NREG-1:0] pend, pend_n;
  logic [REG_AW-1:0] wreg;
  logic [CNT_W-1:0] sc;
  logic done, busy, fin, acc, lw, brs, sbs, mds, mem, hz;
  function automatic logic hit(logic [REG_AW-1:0] s, logic [REG_AW-1:0] d);
    return s != '0 && s == d;
  endfunction
  assign h.forwardAE = hit(h.rsE, h.writeregM) && h.regwriteM ? 2'b10 :
                       hit(h.rsE, h.writeregW) && h.regwriteW ? 2'b01 : 2'b00;
  assign h.forwardBE = hit(h.rtE, h.writeregM) && h.regwriteM ? 2'b10 :
                       hit(h.rtE, h.writeregW) && h.regwriteW ? 2'b01 : 2'b00;
  assign h.forwardAD = hit(h.rsD, h.writeregM) && h.regwriteM;
  assign h.forwardBD = hit(h.rtD, h.writeregM) && h.regwriteM;
  assign busy = st == BUSY;
  assign lw   = h.memtoregE && (hit(h.rsD, h.writeregE) || hit(h.rtD, h.writeregE));
  assign brs  = h.branchD && ((h.regwriteE && (hit(h.rsD, h.writeregE) || hit(h.rtD, h.writeregE))) ||
                              (h.memtoregM && (hit(h.rsD, h.writeregM) || hit(h.rtD, h.writeregM))));
  assign sbs  = pend[h.rsD] || pend[h.rtD] ||
                (h.mdstartE && (hit(h.rsD, h.writeregE) || hit(h.rtD, h.writeregE)));
  assign mds  = h.mdstartE && busy && cnt != '0;
  assign mem  = h.memaccessM && !h.dmem_ready;
  assign hz   = lw || brs || sbs;
  assign fin  = busy && cnt == '0;
  assign acc  = h.mdstartE && !mem && !mds;
  assign h.stallF = mem || mds || hz;
  assign h.stallD = mem || mds || hz;
  assign h.stallE = mem || mds;
  assign h.stallM = mem;
  assign h.flushW = mem;
  assign h.flushM = !mem && mds;
  assign h.flushE = !mem && !mds && hz;
  // retire the finishing op before the new accept so a same-register reissue stays pending
  assign pend_n = (pend & ~(fin ? NREG'(1) << wreg : '0)) |
                  (acc && h.writeregE != '0 ? NREG'(1) << h.writeregE : '0);
  assign h.md_busy = busy;
  assign h.md_done = done;
  assign h.md_wreg = wreg;
  assign h.stall_cycles = sc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      cnt  <= '0;
      pend <= '0;
      wreg <= '0;
      done <= 1'b0;
      sc   <= '0;
    end else begin
      pend <= pend_n;
      done <= fin;
      sc   <= h.stallF && !(&sc) ? sc + 1'b1 : sc;
      if (acc) begin
        st   <= BUSY;
        cnt  <= CW'(MD_LAT - 1);
        wreg <= h.writeregE;
      end else if (fin) st <= IDLE;
      else if (busy) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// tb_hazard_ctrl_sb: directed checks of forwarding, stalls, scoreboard, memory freeze and counter
module tb_hazard_ctrl_sb;
  logic clk = 0, rst_n = 0;
  int n = 0, err = 0;
  always #5 clk = ~clk;
  hazard_ctrl_sb_if hi0 ();
  hazard_ctrl_sb_if #(.CNT_W(2)) hi1 ();
  hazard_ctrl_sb u0 (.clk(clk), .rst_n(rst_n), .h(hi0.slave));
  hazard_ctrl_sb #(.CNT_W(2)) u1 (.clk(clk), .rst_n(rst_n), .h(hi1.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    if (obs !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    {hi0.rsD, hi0.rtD, hi0.rsE, hi0.rtE, hi0.writeregE, hi0.writeregM, hi0.writeregW} = '0;
    {hi0.regwriteE, hi0.regwriteM, hi0.regwriteW, hi0.memtoregE, hi0.memtoregM} = '0;
    {hi0.branchD, hi0.mdstartE, hi0.memaccessM} = '0;
    hi0.dmem_ready = 1;
  endtask
  task automatic nx();
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    {hi1.rsD, hi1.rtD, hi1.rsE, hi1.rtE, hi1.writeregE, hi1.writeregM, hi1.writeregW} = '0;
    {hi1.regwriteE, hi1.regwriteM, hi1.regwriteW, hi1.memtoregE, hi1.memtoregM} = '0;
    {hi1.branchD, hi1.mdstartE, hi1.memaccessM} = '0;
    hi1.dmem_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_busy", hi0.md_busy, 0);
    chk("rst_done", hi0.md_done, 0);
    chk("rst_wreg", hi0.md_wreg, 0);
    chk("rst_sc", hi0.stall_cycles, 0);
    chk("rst_stallF", hi0.stallF, 0);
    rst_n = 1;
    nx();
    // load-use
    hi0.memtoregE = 1; hi0.regwriteE = 1; hi0.writeregE = 8; hi0.rsD = 8;
    @(negedge clk);
    chk("lu_stallF", hi0.stallF, 1);
    chk("lu_stallD", hi0.stallD, 1);
    chk("lu_flushE", hi0.flushE, 1);
    chk("lu_stallE", hi0.stallE, 0);
    nx();
    idle(); hi0.regwriteW = 1; hi0.writeregW = 8; hi0.rsE = 8;
    @(negedge clk);
    chk("lu_fwdAE", hi0.forwardAE, 2'b01);
    chk("lu_nostall", hi0.stallF, 0);
    chk("lu_sc", hi0.stall_cycles, 1);
    nx();
    // forward priority
    idle(); hi0.writeregM = 5; hi0.writeregW = 5; hi0.regwriteM = 1; hi0.regwriteW = 1;
    hi0.rsE = 5; hi0.rtE = 5; hi0.rsD = 5;
    @(negedge clk);
    chk("fw_AE_M", hi0.forwardAE, 2'b10);
    chk("fw_BE_M", hi0.forwardBE, 2'b10);
    chk("fw_AD", hi0.forwardAD, 1);
    chk("fw_BD", hi0.forwardBD, 0);
    nx();
    hi0.rsE = 0; hi0.regwriteM = 0;
    @(negedge clk);
    chk("fw_AE_r0", hi0.forwardAE, 2'b00);
    chk("fw_BE_W", hi0.forwardBE, 2'b01);
    chk("fw_AD_off", hi0.forwardAD, 0);
    nx();
    // branch stall
    idle(); hi0.branchD = 1; hi0.regwriteE = 1; hi0.writeregE = 7; hi0.rtD = 7;
    @(negedge clk);
    chk("br_stallF", hi0.stallF, 1);
    chk("br_flushE", hi0.flushE, 1);
    nx();
    hi0.branchD = 0;
    @(negedge clk);
    chk("br_off", hi0.stallF, 0);
    nx();
    // scoreboard
    idle(); hi0.mdstartE = 1; hi0.writeregE = 9;
    @(negedge clk);
    chk("sb_acc_stall", hi0.stallF, 0);
    nx();
    idle(); hi0.rsD = 9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sb_busy", hi0.md_busy, 1);
      chk("sb_stall", hi0.stallF, 1);
      chk("sb_done_lo", hi0.md_done, 0);
      nx();
    end
    @(negedge clk);
    chk("sb_done", hi0.md_done, 1);
    chk("sb_wreg", hi0.md_wreg, 9);
    chk("sb_release", hi0.stallF, 0);
    chk("sb_idle", hi0.md_busy, 0);
    chk("sb_sc", hi0.stall_cycles, 6);
    nx();
    @(negedge clk);
    chk("sb_done_1cyc", hi0.md_done, 0);
    nx();
    // structural stall and back-to-back accept
    idle(); hi0.mdstartE = 1; hi0.writeregE = 10;
    nx();
    hi0.writeregE = 11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("md_stallE", hi0.stallE, 1);
      chk("md_flushM", hi0.flushM, 1);
      chk("md_flushE", hi0.flushE, 0);
      nx();
    end
    @(negedge clk);
    chk("md_acc_stallE", hi0.stallE, 0);
    chk("md_acc_flushM", hi0.flushM, 0);
    nx();
    idle();
    @(negedge clk);
    chk("md_b2b_done", hi0.md_done, 1);
    chk("md_b2b_wreg", hi0.md_wreg, 11);
    chk("md_b2b_busy", hi0.md_busy, 1);
    repeat (4) nx();
    @(negedge clk);
    chk("md_b2b_done2", hi0.md_done, 1);
    chk("md_b2b_idle", hi0.md_busy, 0);
    chk("md_sc", hi0.stall_cycles, 9);
    nx();
    // memory freeze, with a concurrent load-use that must not bubble E
    idle(); hi0.memaccessM = 1; hi0.dmem_ready = 0;
    hi0.memtoregE = 1; hi0.writeregE = 8; hi0.rsD = 8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mem_stallF", hi0.stallF, 1);
      chk("mem_stallE", hi0.stallE, 1);
      chk("mem_stallM", hi0.stallM, 1);
      chk("mem_flushW", hi0.flushW, 1);
      chk("mem_flushE", hi0.flushE, 0);
      nx();
    end
    idle();
    @(negedge clk);
    chk("mem_stallM_off", hi0.stallM, 0);
    chk("mem_sc", hi0.stall_cycles, 12);
    nx();
    // saturation on the narrow counter
    hi1.memaccessM = 1; hi1.dmem_ready = 0;
    repeat (6) nx();
    hi1.memaccessM = 0; hi1.dmem_ready = 1;
    @(negedge clk);
    chk("sat_sc", hi1.stall_cycles, 3);
    nx();
    // reset mid-op
    idle(); hi0.mdstartE = 1; hi0.writeregE = 12;
    nx();
    idle();
    repeat (2) nx();
    rst_n = 0;
    #1;
    chk("rm_busy", hi0.md_busy, 0);
    chk("rm_sc", hi0.stall_cycles, 0);
    hi0.rsD = 12;
    #1;
    chk("rm_pend", hi0.stallF, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rm_nodone", hi0.md_done, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n, err);
    $finish;
  end
endmodule
